seven_seg_scanner: RTL and testbench

//  Time-multiplexed driver for a common-anode NUM_DIGITS seven-segment display; display end of the BCD counter path.

---
 rtl/seven_seg_pkg.sv | 30 +++
 rtl/seven_seg_scanner_if.sv | 34 +++
 rtl/seg_scan_prescaler.sv | 49 ++++
 rtl/seven_seg_scanner.sv | 162 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types, constants and BCD decoder for the seven-segment scanner
// Contents:
//   SEG_BLANK     all segments off (active-low)
//   scan_state_t  per-slot phase: DEAD (anodes off) or ON (digit lit)
//   bcd_to_seg    4-bit code -> active-low {g,f,e,d,c,b,a}; codes 10..15 blank
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {DEAD, ON} scan_state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pattern;
    case (bcd)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - data and display bundle between a digit source and the scanner
// Signals:
//   enable      scan run/hold
//   load        1-cycle strobe capturing digits_in/dp_in
//   digits_in   packed BCD digits, [3:0] = digit 0 (rightmost)
//   dp_in       decimal point per digit, 1 = lit
//   seg, dp     active-low segment and decimal-point drive
//   an          active-low anode enables
//   frame_done  1-cycle pulse after the last slot of a frame
// Modports: master = digit source / display sink, slave = scanner
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output enable, load, digits_in, dp_in,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  enable, load, digits_in, dp_in,
    output seg, dp, an, frame_done
  );

endinterface

// File: rtl/seg_scan_prescaler.sv
// rtl/seg_scan_prescaler.sv - slot counter and digit index for the seven-segment scanner
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   enable       counting runs when high, holds when low
//   idx          digit currently being scanned
//   slot_start   high on the last count of a slot; the next edge starts a new slot
//   dead_end     high on the last dead-time count; the next edge lights the digit
//   frame_end    slot_start on the last digit; the next edge starts a new frame
module seg_scan_prescaler #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [IDX_W-1:0] idx,
  output logic             slot_start,
  output logic             dead_end,
  output logic             frame_end
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (enable) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign slot_start = enable && (cnt == CNT_LAST);
  assign dead_end   = enable && (cnt == DEAD_LAST);
  assign frame_end  = slot_start && (idx == IDX_LAST);

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - double-buffered, dead-timed common-anode seven-segment scanner
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    seven_seg_scanner_if.slave: enable, load, digits_in, dp_in in; seg, dp, an, frame_done out
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  seven_seg_scanner_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [IDX_W-1:0]        idx;
  logic                    slot_start;
  logic                    dead_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active;
  logic [NUM_DIGITS-1:0]   active_dp;

  scan_state_t             state;
  scan_state_t             state_next;

  logic [3:0]              digit;
  logic                    digit_dp;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic [6:0]              seg_lit;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_done_q;

  seg_scan_prescaler #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .enable     (bus.enable),
    .idx        (idx),
    .slot_start (slot_start),
    .dead_end   (dead_end),
    .frame_end  (frame_end)
  );

  // Shadow takes every load; active only changes on a frame boundary, and a
  // load on that same cycle goes straight through so it is not a frame late.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      shadow_dp <= '0;
      active    <= '0;
      active_dp <= '0;
    end else begin
      if (bus.load) begin
        shadow    <= bus.digits_in;
        shadow_dp <= bus.dp_in;
      end
      if (frame_end) begin
        active    <= bus.load ? bus.digits_in : shadow;
        active_dp <= bus.load ? bus.dp_in : shadow_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DEAD;
    end else begin
      state <= state_next;
    end
  end

  // Strobes are already gated by enable, so the phase freezes with the counter.
  always_comb begin
    state_next = state;
    if (slot_start) begin
      state_next = DEAD;
    end else if (dead_end) begin
      state_next = ON;
    end
  end

  always_comb begin
    digit    = '0;
    digit_dp = 1'b0;
    an_lit   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        digit     = active[4*i +: 4];
        digit_dp  = active_dp[i];
        an_lit[i] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // zero_above[i]: digit i and every more significant digit are zero.
  logic [NUM_DIGITS-1:0] zero_above;

  always_comb begin
    zero_above    = '0;
    zero_above[NUM_DIGITS-1] = (active[4*(NUM_DIGITS-1) +: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
      zero_above[i] = zero_above[i+1] && (active[4*i +: 4] == 4'd0);
    end
    zero_above[0] = 1'b0;
  end

  always_comb begin
    blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        blank = zero_above[i];
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign seg_lit = blank ? SEG_BLANK : bcd_to_seg(digit);

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (bus.enable && state == ON) begin
        seg_q <= seg_lit;
        dp_q  <= ~digit_dp;
        an_q  <= an_lit;
      end else begin
        seg_q <= SEG_BLANK;
        dp_q  <= 1'b1;
        an_q  <= '1;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner against a frame-position model
module tb_seven_seg_scanner;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = ND * RD;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seven_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: position in the frame is just the number of enabled cycles since reset.
  int          ticks;
  logic [15:0] m_shadow, m_active;
  logic [3:0]  m_shadow_dp, m_active_dp;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_dp;
  logic        exp_fd;

  task automatic tick();
    int pos, i, c;
    if (reset) begin
      exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1; exp_fd = 1'b0;
      ticks = 0;
      m_shadow = '0; m_active = '0; m_shadow_dp = '0; m_active_dp = '0;
    end else begin
      pos = ticks % FRAME;
      i   = pos / RD;
      c   = pos % RD;
      exp_fd = bus.enable && (pos == FRAME - 1);
      if (!bus.enable || c < DC) begin
        exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1;
      end else begin
        exp_an  = ~(4'b0001 << i);
        exp_seg = seg_tab[m_active[4*i +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (m_active >> (4*i)) == 16'h0) exp_seg = 7'h7F;
`endif
        exp_dp  = ~m_active_dp[i];
      end
      if (bus.enable && pos == FRAME - 1) begin
        m_active    = bus.load ? bus.digits_in : m_shadow;
        m_active_dp = bus.load ? bus.dp_in : m_shadow_dp;
      end
      if (bus.load) begin
        m_shadow    = bus.digits_in;
        m_shadow_dp = bus.dp_in;
      end
      if (bus.enable) ticks++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.enable = 1'b0; bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b0; bus.enable = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      n_checks++;
      if (bus.seg !== exp_seg || bus.an !== exp_an || bus.dp !== exp_dp || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL reset_prescan: seg=%h an=%h dp=%b fd=%b expected seg=%h an=%h dp=%b fd=%b",
                 bus.seg, bus.an, bus.dp, bus.frame_done, exp_seg, exp_an, exp_dp, exp_fd);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.seg !== 7'h7F || bus.an !== 4'hF || bus.dp !== 1'b1 || bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: seg=%h an=%h dp=%b fd=%b expected seg=7f an=f dp=1 fd=0",
                 bus.seg, bus.an, bus.dp, bus.frame_done);
      end
    end
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if (bus.an !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_restart_dead: an=%h expected f", bus.an);
    end
    tick();
    n_checks++;
    if (bus.an !== 4'hE || bus.seg !== 7'h40) begin
      n_fail++;
      $display("FAIL reset_restart_idx0: an=%h seg=%h expected an=e seg=40", bus.an, bus.seg);
    end
  endtask

  task automatic test_load_display();
    int n_e, n_d, n_b, n_7, n_off, guard;
    n_e = 0; n_d = 0; n_b = 0; n_7 = 0; n_off = 0; guard = 0;
    bus.digits_in = 16'h1234; bus.dp_in = 4'b0100; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    do begin
      tick();
      guard++;
      n_checks++;
      if (bus.seg !== exp_seg || bus.an !== exp_an || bus.dp !== exp_dp || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL load_wait: seg=%h an=%h dp=%b fd=%b expected seg=%h an=%h dp=%b fd=%b",
                 bus.seg, bus.an, bus.dp, bus.frame_done, exp_seg, exp_an, exp_dp, exp_fd);
      end
    end while (!exp_fd && guard < 64);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      n_checks++;
      if (bus.seg !== exp_seg || bus.an !== exp_an || bus.dp !== exp_dp || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL load_frame: seg=%h an=%h dp=%b fd=%b expected seg=%h an=%h dp=%b fd=%b",
                 bus.seg, bus.an, bus.dp, bus.frame_done, exp_seg, exp_an, exp_dp, exp_fd);
      end
      if (bus.an == 4'hE && bus.seg == 7'h19) n_e++;
      if (bus.an == 4'hD && bus.seg == 7'h30 && bus.dp == 1'b1) n_d++;
      if (bus.an == 4'hB && bus.seg == 7'h24 && bus.dp == 1'b0) n_b++;
      if (bus.an == 4'h7 && bus.seg == 7'h79) n_7++;
      if (bus.an == 4'hF) n_off++;
    end
    n_checks++;
    if (n_e != 6 || n_d != 6 || n_b != 6 || n_7 != 6 || n_off != 8) begin
      n_fail++;
      $display("FAIL load_1234_slots: lit counts e=%0d d=%0d b=%0d 7=%0d off=%0d expected 6 6 6 6 8",
               n_e, n_d, n_b, n_7, n_off);
    end
  endtask

  task automatic test_mid_frame_load();
    int n_old, n_new, n_fd, guard;
    n_old = 0; n_new = 0; n_fd = 0; guard = 0;
    for (int k = 0; k < 10; k++) tick();
    bus.digits_in = 16'h5678; bus.dp_in = 4'b0000; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    do begin
      tick();
      guard++;
      n_checks++;
      if (bus.seg !== exp_seg || bus.an !== exp_an || bus.dp !== exp_dp || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL midload_cur: seg=%h an=%h dp=%b fd=%b expected seg=%h an=%h dp=%b fd=%b",
                 bus.seg, bus.an, bus.dp, bus.frame_done, exp_seg, exp_an, exp_dp, exp_fd);
      end
      if (bus.an == 4'h7 && bus.seg == 7'h79) n_old++;
    end while (!exp_fd && guard < 64);
    n_checks++;
    if (n_old != 6) begin
      n_fail++;
      $display("FAIL midload_keeps_old: digit3 '1' cycles=%0d expected 6", n_old);
    end
    for (int k = 0; k < 2*FRAME; k++) begin
      tick();
      n_checks++;
      if (bus.seg !== exp_seg || bus.an !== exp_an || bus.dp !== exp_dp || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL midload_next: seg=%h an=%h dp=%b fd=%b expected seg=%h an=%h dp=%b fd=%b",
                 bus.seg, bus.an, bus.dp, bus.frame_done, exp_seg, exp_an, exp_dp, exp_fd);
      end
      if (bus.an == 4'h7 && bus.seg == 7'h12) n_new++;
      if (bus.frame_done === 1'b1) n_fd++;
    end
    n_checks++;
    if (n_new != 12 || n_fd != 2) begin
      n_fail++;
      $display("FAIL midload_new_frames: digit3 '5' cycles=%0d frame_done=%0d expected 12 and 2", n_new, n_fd);
    end
  endtask

  task automatic test_boundary_load();
    int n_d0, n_hi, guard;
    n_d0 = 0; n_hi = 0; guard = 0;
    while (ticks % FRAME != FRAME - 1 && guard < 64) begin
      tick();
      guard++;
    end
    bus.digits_in = 16'h0009; bus.dp_in = 4'b0000; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_checks++;
    if (bus.frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_fd: frame_done=%b expected 1", bus.frame_done);
    end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      n_checks++;
      if (bus.seg !== exp_seg || bus.an !== exp_an || bus.dp !== exp_dp || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL boundary_frame: seg=%h an=%h dp=%b fd=%b expected seg=%h an=%h dp=%b fd=%b",
                 bus.seg, bus.an, bus.dp, bus.frame_done, exp_seg, exp_an, exp_dp, exp_fd);
      end
      if (bus.an == 4'hE && bus.seg == 7'h10) n_d0++;
`ifdef LEADING_ZERO_BLANK_EN
      if (bus.an != 4'hF && bus.an != 4'hE && bus.seg == 7'h7F) n_hi++;
`else
      if (bus.an != 4'hF && bus.an != 4'hE && bus.seg == 7'h40) n_hi++;
`endif
    end
    n_checks++;
    if (n_d0 != 6 || n_hi != 18) begin
      n_fail++;
      $display("FAIL boundary_bypass_0009: digit0 cycles=%0d upper cycles=%0d expected 6 and 18", n_d0, n_hi);
    end
  endtask

  task automatic test_blank_codes();
    int n0, n1, n3, guard;
    n0 = 0; n1 = 0; n3 = 0; guard = 0;
    bus.digits_in = 16'h00AF; bus.dp_in = 4'b0001; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    while (!exp_fd && guard < 64) begin
      tick();
      guard++;
    end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      n_checks++;
      if (bus.seg !== exp_seg || bus.an !== exp_an || bus.dp !== exp_dp || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL blank_frame: seg=%h an=%h dp=%b fd=%b expected seg=%h an=%h dp=%b fd=%b",
                 bus.seg, bus.an, bus.dp, bus.frame_done, exp_seg, exp_an, exp_dp, exp_fd);
      end
      if (bus.an == 4'hE && bus.seg == 7'h7F && bus.dp == 1'b0) n0++;
      if (bus.an == 4'hD && bus.seg == 7'h7F) n1++;
      if (bus.an == 4'h7) n3++;
    end
    n_checks++;
    if (n0 != 6 || n1 != 6 || n3 != 6) begin
      n_fail++;
      $display("FAIL blank_codes_00af: idx0=%0d idx1=%0d an3=%0d expected 6 6 6", n0, n1, n3);
    end
  endtask

  task automatic test_enable_pause();
    int guard;
    guard = 0;
    while (ticks % RD != 4 && guard < 16) begin
      tick();
      guard++;
    end
    bus.enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (bus.seg !== 7'h7F || bus.an !== 4'hF || bus.dp !== 1'b1 || bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_outputs: seg=%h an=%h dp=%b fd=%b expected seg=7f an=f dp=1 fd=0",
                 bus.seg, bus.an, bus.dp, bus.frame_done);
      end
    end
    bus.enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_checks++;
      if (bus.seg !== exp_seg || bus.an !== exp_an || bus.dp !== exp_dp || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL pause_resume: seg=%h an=%h dp=%b fd=%b expected seg=%h an=%h dp=%b fd=%b",
                 bus.seg, bus.an, bus.dp, bus.frame_done, exp_seg, exp_an, exp_dp, exp_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(0, 199) == 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.load   = ($urandom_range(0, 7) == 0);
      bus.digits_in = 16'($urandom);
      if ($urandom_range(0, 1) == 1) bus.digits_in[15:8] = 8'h00;
      bus.dp_in  = 4'($urandom);
      tick();
      n_checks++;
      if (bus.seg !== exp_seg || bus.an !== exp_an || bus.dp !== exp_dp || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL random_%0d: seg=%h an=%h dp=%b fd=%b expected seg=%h an=%h dp=%b fd=%b",
                 k, bus.seg, bus.an, bus.dp, bus.frame_done, exp_seg, exp_an, exp_dp, exp_fd);
      end
    end
    reset = 1'b0; bus.load = 1'b0; bus.enable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_display();
    test_mid_frame_load();
    test_boundary_load();
    test_blank_codes();
    test_enable_pause();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
